writeback_pipeline: RTL and testbench
=====================================

// Module: writeback_pipeline
// PURPOSE
//  Post-execute pipeline (stage 1 = MEM, stage 2 = WB) of the 16-bit simpleCPU. Registers the executing
//  instruction and its Rb result, captures load data, and decodes each stage's write flags.
//  Drives the register-file write ports from stage 2.
//  Also sources the forwarding unit's instr1/instr2, ALUd1/2, memoryd1/2 and rawf/rbwf 1/2 inputs.
// PARAMETERS
//  DATA_W     16       data / instruction width
//  REG_AW     3        register address width (8 GPRs)
//  NOP_INSTR  16'h0000 bubble encoding (op1=00, all-zero: writes nothing)
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  ex_instr    in   16      instruction leaving EX
//  ex_rbdata   in   16      Rb result from EX (ALU, imm or IN data, already muxed)
//  hold_i      in   1       freeze both stages this cycle
//  flush_i     in   1       replace the instruction entering stage 1 with NOP
//  mem_rdata   in   16      sync memory read data, valid in the first cycle an LD sits in stage 1
//  instr1      out  16      stage-1 instruction
//  ALUd1       out  16      stage-1 Rb data
//  memoryd1    out  16      stage-1 load data (live or held)
//  rawf1/rbwf1 out  1 each  stage-1 Ra/Rb write flags
//  instr2      out  16      stage-2 instruction
//  ALUd2       out  16      stage-2 Rb data
//  memoryd2    out  16      stage-2 load data
//  rawf2/rbwf2 out  1 each  stage-2 Ra/Rb write flags
//  rf_wea      out  1       Ra write enable
//  rf_waa      out  3       Ra write address
//  rf_wda      out  16      Ra write data
//  rf_web      out  1       Rb write enable
//  rf_wab      out  3       Rb write address
//  rf_wdb      out  16      Rb write data
//  retired_cnt out  16      present only with WBP_PERF_CNT_EN
// BEHAVIOUR
//  Reset: instr1=instr2=NOP_INSTR; ALUd1/2, memoryd2, skid register = 0; skid_valid = 0; all flags = 0; all rf_we* = 0.
//  Write-flag decode (combinational per stage; op1=[15:14], op2=[13:11], op3=[7:4]):
//   op1=00, instr!=0                      -> rawf=1 (LD writes Ra=[13:11])
//   op1=01                                -> no write (ST)
//   op1=10, op2 in {000,001,010}          -> rbwf=1
//   op1=11, op3 in {0000-0100,0110,1000-1100} -> rbwf=1 (Rb=[10:8]); 0101 CMP and 1101 OUT write nothing
//   rawf and rbwf are never both 1.
//  Advance (hold_i=0), each clock:
//   stage2 <= stage1: instr, ALUd, memoryd1 value.
//   stage1 <= flush_i ? {NOP, 0} : {ex_instr, ex_rbdata}.
//  Hold (hold_i=1): stage1/stage2 registers unchanged; flush_i ignored (upstream keeps it asserted until released).
//  Load-data skid:
//   First hold cycle with an LD in stage 1: capture mem_rdata into skid; set skid_valid.
//   memoryd1 = skid_valid ? skid : mem_rdata.
//   skid_valid clears on the first advance.
//  RF write (combinational from stage 2): rf_wea = rawf2 & ~hold_i, rf_waa = instr2[13:11], rf_wda = memoryd2;
//   rf_web = rbwf2 & ~hold_i, rf_wab = instr2[10:8], rf_wdb = ALUd2.
//   A held instruction writes exactly once: in the cycle hold_i drops.
//  Latency: ex_instr -> instr1 = 1 cycle; -> RF write = 2 cycles (no hold).
//  Reset mid-hold: reset wins; both stages become NOP; skid cleared.
// CONFIGURATION
//  WBP_PERF_CNT_EN defined:
//   retired_cnt increments (wraps at 16'hFFFF -> 0) on every advancing cycle where instr2 != NOP_INSTR;
//   reset to 0.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package (cpu_pkg): OP1_LD/ST/IMM/ALU, OP3_* codes, NOP_INSTR, field-slice localparams.
//  Sub-module instr_wflag_dec (instr -> {rawf, rbwf}), instantiated once per stage.
// TESTING
//  1. Reset, then ADD R1,R2 (op3=0000, Rb=2), ex_rbdata=16'h1234 -> cycle+1: rbwf1=1;
//     cycle+2: rf_web=1, rf_wab=2, rf_wdb=16'h1234.
//  2. LD Ra=3 with mem_rdata=16'hBEEF in first stage-1 cycle -> cycle+2: rf_wea=1, rf_waa=3, rf_wda=16'hBEEF.
//  3. LD in stage 1, hold_i=1 for 3 cycles while mem_rdata changes to 16'h0000 -> memoryd1 stays 16'hBEEF;
//     rf_wea pulses exactly once after release.
//  4. flush_i=1 with ex_instr=ADD -> instr1=16'h0000; no RF write two cycles later.
//  5. ST, CMP (op3=0101), OUT (op3=1101) streamed through -> all write flags and rf_we* stay 0.
//  6. rst asserted during hold with valid LD/ADD in flight -> next cycle all outputs at reset values;
//     no RF write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared simpleCPU encodings: opcode enums, instruction field positions and the
// write-back decode helper used by the post-execute pipeline.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 3;
  localparam logic [CPU_DATA_W-1:0] CPU_NOP = 16'h0000;

  // Instruction field positions.
  localparam int OP1_LO = 14;
  localparam int OP2_LO = 11;
  localparam int OP3_LO = 4;
  localparam int RA_LO  = 11;
  localparam int RB_LO  = 8;

  typedef enum logic [1:0] {
    OP1_LD  = 2'b00,
    OP1_ST  = 2'b01,
    OP1_IMM = 2'b10,
    OP1_ALU = 2'b11
  } op1_e;

  typedef enum logic [3:0] {
    OP3_ADD  = 4'b0000,
    OP3_SUB  = 4'b0001,
    OP3_AND  = 4'b0010,
    OP3_OR   = 4'b0011,
    OP3_XOR  = 4'b0100,
    OP3_CMP  = 4'b0101,
    OP3_MOV  = 4'b0110,
    OP3_RSV7 = 4'b0111,
    OP3_SHL  = 4'b1000,
    OP3_SHR  = 4'b1001,
    OP3_ROL  = 4'b1010,
    OP3_ROR  = 4'b1011,
    OP3_IN   = 4'b1100,
    OP3_OUT  = 4'b1101,
    OP3_RSVE = 4'b1110,
    OP3_RSVF = 4'b1111
  } op3_e;

  // Immediate-class op2 values that produce an Rb result.
  localparam logic [2:0] OP2_IMM_WR_MAX = 3'b010;

  typedef struct packed {
    logic rawf;
    logic rbwf;
  } wflags_t;

  // ALU-class instructions write Rb unless they only set flags, drive the
  // output port, or are reserved encodings.
  function automatic logic op3_writes_rb(input logic [3:0] op3);
    case (op3_e'(op3))
      OP3_CMP, OP3_OUT, OP3_RSV7, OP3_RSVE, OP3_RSVF: return 1'b0;
      default:                                        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_wflag_dec.sv
// Register-file write-flag decode for one pipeline stage: instr -> {rawf, rbwf}.
// rawf marks a load into Ra, rbwf marks an Rb result; never both.
module instr_wflag_dec
  import cpu_pkg::*;
#(
  parameter logic [CPU_DATA_W-1:0] NOP_INSTR = CPU_NOP
) (
  input  logic [CPU_DATA_W-1:0] instr,
  output logic                  rawf,
  output logic                  rbwf
);

  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3;
  wflags_t    flags;

  assign op1 = instr[OP1_LO +: 2];
  assign op2 = instr[OP2_LO +: 3];
  assign op3 = instr[OP3_LO +: 4];

  // NOTE: flags gets a default before the case so no branch can infer a latch.
  always_comb begin
    flags = '0;
    case (op1_e'(op1))
      OP1_LD:  flags.rawf = (instr != NOP_INSTR);
      OP1_IMM: flags.rbwf = (op2 <= OP2_IMM_WR_MAX);
      OP1_ALU: flags.rbwf = op3_writes_rb(op3);
      default: flags      = '0;
    endcase
  end

  assign rawf = flags.rawf;
  assign rbwf = flags.rbwf;

endmodule

// File: rtl/writeback_pipeline.sv
// MEM (stage 1) / WB (stage 2) pipeline of the simpleCPU with load-data skid and
// register-file write ports. Optional retired-instruction counter: WBP_PERF_CNT_EN.
module writeback_pipeline
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = CPU_DATA_W,
  parameter int                REG_AW    = CPU_REG_AW,
  parameter logic [DATA_W-1:0] NOP_INSTR = CPU_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_instr,
  input  logic [DATA_W-1:0] ex_rbdata,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr1,
  output logic [DATA_W-1:0] ALUd1,
  output logic [DATA_W-1:0] memoryd1,
  output logic              rawf1,
  output logic              rbwf1,
  output logic [DATA_W-1:0] instr2,
  output logic [DATA_W-1:0] ALUd2,
  output logic [DATA_W-1:0] memoryd2,
  output logic              rawf2,
  output logic              rbwf2,
  output logic              rf_wea,
  output logic [REG_AW-1:0] rf_waa,
  output logic [DATA_W-1:0] rf_wda,
  output logic              rf_web,
  output logic [REG_AW-1:0] rf_wab,
  output logic [DATA_W-1:0] rf_wdb
`ifdef WBP_PERF_CNT_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);

  logic [DATA_W-1:0] instr1_q, instr1_d;
  logic [DATA_W-1:0] alud1_q, alud1_d;
  logic [DATA_W-1:0] instr2_q, instr2_d;
  logic [DATA_W-1:0] alud2_q, alud2_d;
  logic [DATA_W-1:0] memd2_q, memd2_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;

  logic              rawf1_w, rbwf1_w, rawf2_w, rbwf2_w;
  logic [DATA_W-1:0] memd1_w;
  logic              advance;

  instr_wflag_dec #(.NOP_INSTR(NOP_INSTR)) u_dec_s1 (
    .instr (instr1_q),
    .rawf  (rawf1_w),
    .rbwf  (rbwf1_w)
  );

  instr_wflag_dec #(.NOP_INSTR(NOP_INSTR)) u_dec_s2 (
    .instr (instr2_q),
    .rawf  (rawf2_w),
    .rbwf  (rbwf2_w)
  );

  assign advance = ~hold_i;

  // Load data is only presented for one cycle; a held load replays it from the skid.
  assign memd1_w = skid_valid_q ? skid_q : mem_rdata;

  always_comb begin
    instr1_d     = instr1_q;
    alud1_d      = alud1_q;
    instr2_d     = instr2_q;
    alud2_d      = alud2_q;
    memd2_d      = memd2_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (advance) begin
      instr2_d     = instr1_q;
      alud2_d      = alud1_q;
      memd2_d      = memd1_w;
      instr1_d     = flush_i ? NOP_INSTR : ex_instr;
      alud1_d      = flush_i ? '0 : ex_rbdata;
      skid_valid_d = 1'b0;
    end else if (rawf1_w && !skid_valid_q) begin
      skid_d       = mem_rdata;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr1_q     <= NOP_INSTR;
      alud1_q      <= '0;
      instr2_q     <= NOP_INSTR;
      alud2_q      <= '0;
      memd2_q      <= '0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      instr1_q     <= instr1_d;
      alud1_q      <= alud1_d;
      instr2_q     <= instr2_d;
      alud2_q      <= alud2_d;
      memd2_q      <= memd2_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign instr1   = instr1_q;
  assign ALUd1    = alud1_q;
  assign memoryd1 = memd1_w;
  assign rawf1    = rawf1_w;
  assign rbwf1    = rbwf1_w;
  assign instr2   = instr2_q;
  assign ALUd2    = alud2_q;
  assign memoryd2 = memd2_q;
  assign rawf2    = rawf2_w;
  assign rbwf2    = rbwf2_w;

  // Gating with hold makes a stalled instruction write only in its release cycle.
  assign rf_wea = rawf2_w & advance;
  assign rf_waa = instr2_q[RA_LO +: REG_AW];
  assign rf_wda = memd2_q;
  assign rf_web = rbwf2_w & advance;
  assign rf_wab = instr2_q[RB_LO +: REG_AW];
  assign rf_wdb = alud2_q;

`ifdef WBP_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (advance && instr2_q != NOP_INSTR) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_writeback_pipeline.sv
// Directed bench for writeback_pipeline: RF writes are checked against a
// scoreboard queue filled as instructions are issued; stage state is checked directly.
module tb_writeback_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ex_instr, ex_rbdata, mem_rdata;
  logic        hold_i, flush_i;
  logic [15:0] instr1, ALUd1, memoryd1, instr2, ALUd2, memoryd2;
  logic        rawf1, rbwf1, rawf2, rbwf2;
  logic        rf_wea, rf_web;
  logic [2:0]  rf_waa, rf_wab;
  logic [15:0] rf_wda, rf_wdb;
`ifdef WBP_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  writeback_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .ex_instr  (ex_instr),
    .ex_rbdata (ex_rbdata),
    .hold_i    (hold_i),
    .flush_i   (flush_i),
    .mem_rdata (mem_rdata),
    .instr1    (instr1),
    .ALUd1     (ALUd1),
    .memoryd1  (memoryd1),
    .rawf1     (rawf1),
    .rbwf1     (rbwf1),
    .instr2    (instr2),
    .ALUd2     (ALUd2),
    .memoryd2  (memoryd2),
    .rawf2     (rawf2),
    .rbwf2     (rbwf2),
    .rf_wea    (rf_wea),
    .rf_waa    (rf_waa),
    .rf_wda    (rf_wda),
    .rf_web    (rf_web),
    .rf_wab    (rf_wab),
    .rf_wdb    (rf_wdb)
`ifdef WBP_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [15:0] NOP    = 16'h0000;
  localparam logic [15:0] ADD12  = 16'hCA00;  // ALU ADD, Ra=1 Rb=2
  localparam logic [15:0] LD_R3  = 16'h1805;  // LD Ra=3
  localparam logic [15:0] LD_R5  = 16'h2805;  // LD Ra=5

  typedef struct {
    logic        is_a;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic is_a, input logic [2:0] addr, input logic [15:0] data);
    wr_t e;
    e.is_a = is_a;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] rbd);
    ex_instr  = ins;
    ex_rbdata = rbd;
  endtask

  // Sample mid-cycle and retire any RF write against the scoreboard.
  task automatic sample();
    wr_t e;
    @(negedge clk);
    if (rf_wea || rf_web) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", 32'({rf_wea, rf_web}), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("sb_port", 32'({rf_wea, rf_web}), e.is_a ? 32'h2 : 32'h1);
        check("sb_addr", 32'(rf_wea ? rf_waa : rf_wab), 32'(e.addr));
        check("sb_data", 32'(rf_wea ? rf_wda : rf_wdb), 32'(e.data));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t5_instr [5];
  logic        t5_wr    [5];

  initial begin
    rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    drive(NOP, 16'h0);
    mem_rdata = 16'h0;
    t5_instr[0] = 16'h4A05; t5_wr[0] = 1'b0;  // ST
    t5_instr[1] = 16'hCA50; t5_wr[1] = 1'b0;  // CMP
    t5_instr[2] = 16'hCAD0; t5_wr[2] = 1'b0;  // OUT
    t5_instr[3] = 16'h9A00; t5_wr[3] = 1'b0;  // IMM op2=011
    t5_instr[4] = 16'h8234; t5_wr[4] = 1'b1;  // IMM op2=000, Rb=2

    // Reset state.
    cyc(); cyc();
    sample();
    check("rst_instr1", 32'(instr1), 32'h0);
    check("rst_instr2", 32'(instr2), 32'h0);
    check("rst_alud1", 32'(ALUd1), 32'h0);
    check("rst_alud2", 32'(ALUd2), 32'h0);
    check("rst_memd2", 32'(memoryd2), 32'h0);
    check("rst_flags", 32'({rawf1, rbwf1, rawf2, rbwf2}), 32'h0);
    check("rst_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    rst = 1'b0;

    // 1: ADD R1,R2 flows to the Rb write port in two cycles.
    drive(ADD12, 16'h1234); push_wr(1'b0, 3'd2, 16'h1234);
    sample(); cyc();
    drive(NOP, 16'h0);
    sample();
    check("t1_instr1", 32'(instr1), 32'(ADD12));
    check("t1_rbwf1", 32'({rawf1, rbwf1}), 32'h1);
    check("t1_alud1", 32'(ALUd1), 32'h1234);
    cyc();
    sample();
    check("t1_web", 32'({rf_wea, rf_web}), 32'h1);
    check("t1_wab", 32'(rf_wab), 32'd2);
    check("t1_wdb", 32'(rf_wdb), 32'h1234);
    cyc();

    // 2: LD Ra=3 with load data present in its first stage-1 cycle.
    drive(LD_R3, 16'h0); push_wr(1'b1, 3'd3, 16'hBEEF);
    sample(); cyc();
    drive(NOP, 16'h0); mem_rdata = 16'hBEEF;
    sample();
    check("t2_rawf1", 32'({rawf1, rbwf1}), 32'h2);
    check("t2_memd1", 32'(memoryd1), 32'hBEEF);
    cyc();
    mem_rdata = 16'h0;
    sample();
    check("t2_wea", 32'({rf_wea, rf_web}), 32'h2);
    check("t2_waa", 32'(rf_waa), 32'd3);
    check("t2_wda", 32'(rf_wda), 32'hBEEF);
    cyc();

    // 3: LD held for three cycles; skid keeps the data, one write after release.
    drive(LD_R5, 16'h0); push_wr(1'b1, 3'd5, 16'hBEEF);
    sample(); cyc();
    drive(ADD12, 16'h5555); push_wr(1'b0, 3'd2, 16'h5555);
    mem_rdata = 16'hBEEF; hold_i = 1'b1;
    sample();
    check("t3_hold1_memd1", 32'(memoryd1), 32'hBEEF);
    cyc();
    mem_rdata = 16'h0;
    sample();
    check("t3_hold2_memd1", 32'(memoryd1), 32'hBEEF);
    check("t3_hold2_instr1", 32'(instr1), 32'(LD_R5));
    cyc();
    sample();
    check("t3_hold3_memd1", 32'(memoryd1), 32'hBEEF);
    check("t3_hold3_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    hold_i = 1'b0;
    sample();
    check("t3_rel_memd1", 32'(memoryd1), 32'hBEEF);
    cyc();
    drive(NOP, 16'h0); hold_i = 1'b1;
    sample();
    check("t3_s2hold_instr2", 32'(instr2), 32'(LD_R5));
    check("t3_s2hold_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    hold_i = 1'b0;
    sample();
    check("t3_wea_pulse", 32'({rf_wea, rf_web}), 32'h2);
    check("t3_wda", 32'(rf_wda), 32'hBEEF);
    cyc();
    sample();
    check("t3_after_pulse", 32'({rf_wea, rf_web}), 32'h1);
    cyc();

    // 4: flush turns the incoming ADD into a bubble.
    drive(ADD12, 16'h9999); flush_i = 1'b1;
    sample(); cyc();
    drive(NOP, 16'h0); flush_i = 1'b0;
    sample();
    check("t4_instr1", 32'(instr1), 32'h0);
    check("t4_alud1", 32'(ALUd1), 32'h0);
    cyc();
    sample();
    check("t4_no_write", 32'({rf_wea, rf_web}), 32'h0);
    cyc();

    // 5: stream of non-writing encodings, ending with a writing IMM.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        drive(t5_instr[i], 16'hA000 + 16'(i));
        if (t5_wr[i]) push_wr(1'b0, 3'd2, 16'hA000 + 16'(i));
      end else begin
        drive(NOP, 16'h0);
      end
      sample();
      if (i > 0) begin
        check($sformatf("t5_flags1_%0d", i - 1), 32'({rawf1, rbwf1}), 32'({1'b0, t5_wr[i - 1]}));
      end
      if (i > 1) begin
        check($sformatf("t5_we_%0d", i - 2), 32'({rf_wea, rf_web}), 32'({1'b0, t5_wr[i - 2]}));
      end
      cyc();
    end
    sample(); cyc();

    // 6: reset during hold with LD/ADD in flight and a captured skid.
    drive(ADD12, 16'h7777);
    sample(); cyc();
    drive(LD_R3, 16'h0);
    sample(); cyc();
    drive(NOP, 16'h0); hold_i = 1'b1; mem_rdata = 16'hBEEF;
    sample();
    check("t6_held_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    rst = 1'b1;
    sample();
    check("t6_rst_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    rst = 1'b0; hold_i = 1'b0; mem_rdata = 16'h1357;
    sample();
    check("t6_instr1", 32'(instr1), 32'h0);
    check("t6_instr2", 32'(instr2), 32'h0);
    check("t6_alud", 32'({ALUd1, ALUd2}), 32'h0);
    check("t6_memd2", 32'(memoryd2), 32'h0);
    check("t6_skid_clear", 32'(memoryd1), 32'h1357);
    check("t6_flags", 32'({rawf1, rbwf1, rawf2, rbwf2}), 32'h0);
    check("t6_we", 32'({rf_wea, rf_web}), 32'h0);
    cyc();
    sample(); cyc();
    sample(); cyc();

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
